button_event_decoder: RTL
=========================

// Module: button_event_decoder
// PURPOSE
//  Consumes a debounced button level; emits one-cycle event pulses: press, release, short, long, repeat.
//  Sits between each debouncer output and the control FSMs on the BASYS 3 100 MHz domain.
//  Converts a clean level into discrete user-intent events, so downstream logic never edge-detects.
// PARAMETERS
//  LONG_COUNT    27'd100000000  cycles held (after press) before long_pulse; 1 s at 100 MHz
//  REPEAT_COUNT  27'd25000000   cycles between repeat_pulse while long-held (AUTO_REPEAT_EN only)
//  CNT_W         27             counter width; require 2**CNT_W > max(LONG_COUNT, REPEAT_COUNT)
// PORTS
//  clk            input   1  system clock, 100 MHz
//  reset          input   1  asynchronous, active-high; clears all state
//  btn_in         input   1  debounced button level, synchronous to clk, 1 = pressed
//  press_pulse    output  1  one cycle, button went 0->1
//  release_pulse  output  1  one cycle, button went 1->0
//  short_pulse    output  1  one cycle, released before reaching long threshold
//  long_pulse     output  1  one cycle, held for LONG_COUNT cycles
//  repeat_pulse   output  1  one cycle, periodic while long-held (0 without AUTO_REPEAT_EN)
//  held           output  1  level, 1 while FSM is in PRESSED or LONG
// BEHAVIOUR
//  Reset: one clock, asynchronous active-high; state=IDLE, btn_q=0, count=0, all outputs 0.
//  All outputs registered. Edge seen in cycle N (btn_in vs btn_q) -> pulse high in cycle N+1 only.
//  btn_in held high across reset deassertion -> press_pulse on first cycle after reset (btn_q=0).
//  FSM states: IDLE, PRESSED, LONG.
//   IDLE:    rise -> PRESSED, count<=0, press_pulse.
//   PRESSED: count increments each cycle.
//            fall -> IDLE, release_pulse + short_pulse.
//            count==LONG_COUNT-1 with btn_in=1 -> LONG, long_pulse, count<=0.
//   LONG:    fall -> IDLE, release_pulse only, no short_pulse.
//            otherwise count saturates at LONG_COUNT-1 (no repeat build).
//  Simultaneous fall and count==LONG_COUNT-1 in PRESSED: release wins.
//   -> release_pulse + short_pulse, no long_pulse.
//  Counter never wraps.
//  At most one of short/long/repeat asserts per cycle.
//  press_pulse and release_pulse are never in the same cycle.
//  held: 1 the cycle after rise through the cycle of the registered fall; 0 in IDLE.
//  Reset asserted mid-hold -> IDLE immediately, no release/short/long pulse emitted.
// CONFIGURATION
//  `define AUTO_REPEAT_EN:
//   In LONG, count runs 0..REPEAT_COUNT-1 and repeat_pulse fires each time it hits REPEAT_COUNT-1.
//   First repeat fires REPEAT_COUNT cycles after long_pulse; count then returns to 0.
//   Fall on the repeat cycle -> release_pulse only, no repeat_pulse.
//  Without macro: repeat_pulse tied 0, LONG counter logic removed.
// STRUCTURE
//  Shared package button_event_pkg:
//   state encodings (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2)
//   default LONG_COUNT and REPEAT_COUNT constants, shared with debounce instances
//  Sub-module edge_detect: btn_q register; rise/fall strobes; async reset; reused by other input blocks.
//  Top: FSM, counter, registered output stage.
// TESTING  (bench overrides LONG_COUNT=8, REPEAT_COUNT=4, CNT_W=4)
//  1 Short press: btn_in high 3 cycles, then low.
//    -> press_pulse 1 cycle after rise; release_pulse + short_pulse 1 cycle after fall; no long_pulse.
//  2 Long hold: btn_in high 20 cycles.
//    -> long_pulse exactly 8 cycles after press_pulse; on fall, release_pulse only; held=1 throughout.
//  3 Boundary: fall coincides with count==7.
//    -> short_pulse + release_pulse, long_pulse never asserts.
//  4 Reset mid-hold: assert reset at cycle 5 of hold.
//    -> outputs 0 immediately (async); no pulses until a new rise.
//  5 AUTO_REPEAT_EN build, btn_in held 30 cycles.
//    -> long_pulse at +8, repeat_pulse at +12, +16, +20...
//    Same stimulus without macro -> repeat_pulse stays 0.
//  6 btn_in already high at reset release.
//    -> press_pulse on first post-reset cycle; then normal long timing.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared constants and types for button event decoding and the debounce blocks.
// State encodings, default timing counts and the registered event bundle.
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_e;

    localparam int unsigned DEF_CNT_W        = 27;
    localparam int unsigned DEF_LONG_COUNT   = 100_000_000;  // 1 s at 100 MHz
    localparam int unsigned DEF_REPEAT_COUNT = 25_000_000;   // 250 ms at 100 MHz

    typedef struct packed {
        logic press;
        logic rel;
        logic shrt;
        logic lng;
        logic rpt;
        logic held;
    } btn_events_t;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// edge_detect: registers a synchronous level and flags rise/fall against the
// previous sample. Generic so other input blocks can reuse it.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= 1'b0;
        else       r_q <= i_d;
    end

    assign o_rise =  i_d & ~r_q;
    assign o_fall = ~i_d &  r_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat
// pulses plus a held level. Define AUTO_REPEAT_EN to enable repeat pulses in LONG.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_COUNT   = DEF_LONG_COUNT,
    parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    if (((64'd1 << CNT_W) <= 64'(LONG_COUNT)) ||
        ((64'd1 << CNT_W) <= 64'(REPEAT_COUNT))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for LONG_COUNT/REPEAT_COUNT");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
`endif

    logic        w_rise;
    logic        w_fall;
    btn_state_e  r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    btn_events_t r_ev, w_ev_nxt;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (btn_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ev    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ev    <= w_ev_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ev_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = ST_PRESSED;
                    w_count_nxt    = '0;
                    w_ev_nxt.press = 1'b1;
                end
            end
            ST_PRESSED: begin
                // A fall on the threshold cycle still counts as a short press.
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_count_nxt   = '0;
                    w_ev_nxt.rel  = 1'b1;
                    w_ev_nxt.shrt = 1'b1;
                end else if (btn_in && (r_count == LONG_LAST)) begin
                    w_state_nxt  = ST_LONG;
                    w_count_nxt  = '0;
                    w_ev_nxt.lng = 1'b1;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt  = ST_IDLE;
                    w_count_nxt  = '0;
                    w_ev_nxt.rel = 1'b1;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (r_count == REP_LAST) begin
                        w_count_nxt  = '0;
                        w_ev_nxt.rpt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
`else
                    if (r_count != LONG_LAST) w_count_nxt = r_count + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
        w_ev_nxt.held = (w_state_nxt != ST_IDLE);
    end

    assign press_pulse   = r_ev.press;
    assign release_pulse = r_ev.rel;
    assign short_pulse   = r_ev.shrt;
    assign long_pulse    = r_ev.lng;
    assign repeat_pulse  = r_ev.rpt;
    assign held          = r_ev.held;

endmodule
